// File: rtl/scoreboard_warp.sv
// Per-warp scoreboard: RAW/WAR/WAW hazard check for four IB entries, with in-flight tracking entries.
// Allocates a free tag on issue; writeback frees the tag. Ready and the tag index are combinational.
module scoreboard_warp #(
  parameter int SB_DEPTH = 4,
  parameter int ENT_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       IB_Inst_Valid_SB,
  input  logic [5:0]       IB_Src1_Entry0_SB,
  input  logic [5:0]       IB_Src1_Entry1_SB,
  input  logic [5:0]       IB_Src1_Entry2_SB,
  input  logic [5:0]       IB_Src1_Entry3_SB,
  input  logic [5:0]       IB_Src2_Entry0_SB,
  input  logic [5:0]       IB_Src2_Entry1_SB,
  input  logic [5:0]       IB_Src2_Entry2_SB,
  input  logic [5:0]       IB_Src2_Entry3_SB,
  input  logic [5:0]       IB_Dst_Entry0_SB,
  input  logic [5:0]       IB_Dst_Entry1_SB,
  input  logic [5:0]       IB_Dst_Entry2_SB,
  input  logic [5:0]       IB_Dst_Entry3_SB,
  input  logic [3:0]       IB_Issued_SB,
  input  logic             WB_Release_Valid,
  input  logic [ENT_W-1:0] WB_Release_EntNum,
  output logic [3:0]       SB_Ready_Issue_IB,
  output logic             SB_Full,
  output logic             SB_Empty,
  output logic [ENT_W-1:0] SB_EntNum_OC
);

  logic [SB_DEPTH-1:0] valid;
  logic [5:0]          dst_q [SB_DEPTH];
  logic [5:0]          src1 [4];
  logic [5:0]          src2 [4];
  logic [5:0]          dst  [4];
  logic [ENT_W-1:0]    free_idx;
  logic                free_found;
  logic [5:0]          iss_dst;
  logic                issue_ok;

  assign src1 = '{IB_Src1_Entry0_SB, IB_Src1_Entry1_SB, IB_Src1_Entry2_SB, IB_Src1_Entry3_SB};
  assign src2 = '{IB_Src2_Entry0_SB, IB_Src2_Entry1_SB, IB_Src2_Entry2_SB, IB_Src2_Entry3_SB};
  assign dst  = '{IB_Dst_Entry0_SB,  IB_Dst_Entry1_SB,  IB_Dst_Entry2_SB,  IB_Dst_Entry3_SB};

  // Two register fields collide only if both are in use and name the same register.
  function automatic logic reg_eq(input logic [5:0] a, input logic [5:0] b);
    return a[5] & b[5] & (a[4:0] == b[4:0]);
  endfunction

  assign SB_Full  = &valid;
  assign SB_Empty = ~|valid;

  always_comb begin
    SB_Ready_Issue_IB = '0;
    for (int k = 0; k < 4; k++) begin
      SB_Ready_Issue_IB[k] = IB_Inst_Valid_SB[k] & ~SB_Full;
      for (int e = 0; e < SB_DEPTH; e++) begin
        if (valid[e] && (reg_eq(dst_q[e], src1[k]) || reg_eq(dst_q[e], src2[k]) ||
                         reg_eq(dst_q[e], dst[k])))
          SB_Ready_Issue_IB[k] = 1'b0;
      end
      for (int j = 0; j < 4; j++) begin
        if (j < k && IB_Inst_Valid_SB[j] &&
            (reg_eq(dst[j], src1[k]) || reg_eq(dst[j], src2[k]) ||
             reg_eq(src1[j], dst[k]) || reg_eq(src2[j], dst[k]) || reg_eq(dst[j], dst[k])))
          SB_Ready_Issue_IB[k] = 1'b0;
      end
    end
  end

  // Lowest free tag from pre-edge state; a tag released this cycle is not yet free.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int e = 0; e < SB_DEPTH; e++) begin
      if (!valid[e] && !free_found) begin
        free_idx   = ENT_W'(e);
        free_found = 1'b1;
      end
    end
  end

  assign SB_EntNum_OC = free_idx;
  assign issue_ok     = $onehot(IB_Issued_SB) && !SB_Full;

  always_comb begin
    iss_dst = '0;
    for (int k = 0; k < 4; k++)
      if (IB_Issued_SB[k]) iss_dst = dst[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      if (WB_Release_Valid) valid[WB_Release_EntNum] <= 1'b0;
      if (issue_ok)         valid[free_idx]          <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue_ok) dst_q[free_idx] <= iss_dst;
  end

endmodule

// File: tb/tb_scoreboard_warp.sv
// Directed bench for scoreboard_warp: hazards, allocation order, full/empty, release and reset.
module tb_scoreboard_warp;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ib_valid;
  logic [5:0] src1 [4];
  logic [5:0] src2 [4];
  logic [5:0] dst  [4];
  logic [3:0] issued;
  logic       rel_vld;
  logic [1:0] rel_ent;
  logic [3:0] ready;
  logic       full, empty;
  logic [1:0] entnum;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  scoreboard_warp #(.SB_DEPTH(4), .ENT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .IB_Inst_Valid_SB(ib_valid),
    .IB_Src1_Entry0_SB(src1[0]), .IB_Src1_Entry1_SB(src1[1]),
    .IB_Src1_Entry2_SB(src1[2]), .IB_Src1_Entry3_SB(src1[3]),
    .IB_Src2_Entry0_SB(src2[0]), .IB_Src2_Entry1_SB(src2[1]),
    .IB_Src2_Entry2_SB(src2[2]), .IB_Src2_Entry3_SB(src2[3]),
    .IB_Dst_Entry0_SB(dst[0]), .IB_Dst_Entry1_SB(dst[1]),
    .IB_Dst_Entry2_SB(dst[2]), .IB_Dst_Entry3_SB(dst[3]),
    .IB_Issued_SB(issued), .WB_Release_Valid(rel_vld), .WB_Release_EntNum(rel_ent),
    .SB_Ready_Issue_IB(ready), .SB_Full(full), .SB_Empty(empty), .SB_EntNum_OC(entnum)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ib();
    ib_valid = '0;
    issued   = '0;
    rel_vld  = 1'b0;
    rel_ent  = '0;
    for (int i = 0; i < 4; i++) begin
      src1[i] = '0;
      src2[i] = '0;
      dst[i]  = '0;
    end
  endtask

  task automatic set_ib(input int i, input logic [5:0] s1, input logic [5:0] s2, input logic [5:0] d);
    src1[i] = s1;
    src2[i] = s2;
    dst[i]  = d;
    ib_valid[i] = 1'b1;
  endtask

  task automatic issue_one(input logic [3:0] oh);
    issued = oh;
    tick();
    issued = '0;
    #1;
  endtask

  task automatic release_one(input logic [1:0] e);
    rel_vld = 1'b1;
    rel_ent = e;
    tick();
    rel_vld = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_ib();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({empty, full, entnum, ready} !== {1'b1, 1'b0, 2'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset: empty/full/entnum/ready got %b/%b/%0d/%b want 1/0/0/0000", empty, full, entnum, ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_ready();
    clear_ib();
    set_ib(0, 6'b100011, 6'b100100, 6'b100101);
    #1;
    n_checks++;
    if ({ready, empty, entnum} !== {4'b0001, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL basic_ready: ready/empty/entnum got %b/%b/%0d want 0001/1/0", ready, empty, entnum);
    end
  endtask

  task automatic test_raw_inflight();
    issue_one(4'b0001);
    n_checks++;
    if ({empty, entnum} !== {1'b0, 2'd1}) begin
      n_fail++;
      $display("FAIL raw_alloc: empty/entnum got %b/%0d want 0/1", empty, entnum);
    end
    set_ib(0, 6'b100101, 6'b000000, 6'b000000);
    #1;
    n_checks++;
    if (ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL raw_block: ready got %b want 0000", ready);
    end
    rel_vld = 1'b1;
    rel_ent = 2'd0;
    #1;
    n_checks++;
    if (ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL raw_no_bypass: ready got %b want 0000", ready);
    end
    tick();
    rel_vld = 1'b0;
    #1;
    n_checks++;
    if ({ready, empty} !== {4'b0001, 1'b1}) begin
      n_fail++;
      $display("FAIL raw_release: ready/empty got %b/%b want 0001/1", ready, empty);
    end
  endtask

  task automatic test_ib_hazards();
    clear_ib();
    set_ib(0, 6'b000000, 6'b000000, 6'b100111);
    set_ib(1, 6'b000000, 6'b100111, 6'b000000);
    #1;
    n_checks++;
    if (ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL ib_raw: ready got %b want 0001", ready);
    end
    set_ib(0, 6'b100010, 6'b000000, 6'b000000);
    set_ib(1, 6'b000000, 6'b000000, 6'b100010);
    #1;
    n_checks++;
    if (ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL ib_war: ready got %b want 0001", ready);
    end
    // Entry1 WAW on r3 with entry0; entry2 independent; entry3 reads r3 written by entry0.
    set_ib(0, 6'b000000, 6'b000000, 6'b100011);
    set_ib(1, 6'b000000, 6'b000000, 6'b100011);
    set_ib(2, 6'b101000, 6'b101001, 6'b101010);
    set_ib(3, 6'b100011, 6'b000000, 6'b001010);
    #1;
    n_checks++;
    if (ready !== 4'b0101) begin
      n_fail++;
      $display("FAIL ib_waw_mix: ready got %b want 0101", ready);
    end
    // Unused operand fields (bit5=0) never conflict even when addresses match.
    set_ib(1, 6'b000000, 6'b000000, 6'b000011);
    set_ib(3, 6'b000011, 6'b000000, 6'b001010);
    #1;
    n_checks++;
    if (ready !== 4'b1111) begin
      n_fail++;
      $display("FAIL ib_unused: ready got %b want 1111", ready);
    end
  endtask

  task automatic test_back_to_back_full();
    logic [1:0] exp_idx;
    clear_ib();
    for (int i = 0; i < 4; i++) begin
      exp_idx = 2'(i);
      set_ib(0, 6'b000000, 6'b000000, 6'(6'b100001 + i));
      issued = 4'b0001;
      #1;
      n_checks++;
      if ({entnum, ready[0]} !== {exp_idx, 1'b1}) begin
        n_fail++;
        $display("FAIL b2b_alloc%0d: entnum/ready0 got %0d/%b want %0d/1", i, entnum, ready[0], exp_idx);
      end
      tick();
    end
    issued = '0;
    set_ib(0, 6'b000000, 6'b000000, 6'b101010);
    #1;
    n_checks++;
    if ({full, empty, ready} !== {1'b1, 1'b0, 4'b0000}) begin
      n_fail++;
      $display("FAIL b2b_full: full/empty/ready got %b/%b/%b want 1/0/0000", full, empty, ready);
    end
    issue_one(4'b0001);
    release_one(2'd2);
    n_checks++;
    if ({full, entnum} !== {1'b0, 2'd2}) begin
      n_fail++;
      $display("FAIL b2b_release2: full/entnum got %b/%0d want 0/2", full, entnum);
    end
    issue_one(4'b0001);
    n_checks++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_realloc: full got %b want 1", full);
    end
    for (int i = 0; i < 4; i++) release_one(2'(i));
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drain: empty got %b want 1", empty);
    end
  endtask

  task automatic test_simultaneous();
    clear_ib();
    set_ib(0, 6'b000000, 6'b000000, 6'b110000);
    issue_one(4'b0001);
    set_ib(0, 6'b000000, 6'b000000, 6'b110001);
    issue_one(4'b0001);
    set_ib(0, 6'b000000, 6'b000000, 6'b110010);
    issued  = 4'b0001;
    rel_vld = 1'b1;
    rel_ent = 2'd0;
    #1;
    n_checks++;
    if (entnum !== 2'd2) begin
      n_fail++;
      $display("FAIL simul_idx: entnum got %0d want 2", entnum);
    end
    tick();
    issued  = '0;
    rel_vld = 1'b0;
    #1;
    // Valid=0110: lowest free index is 0, neither full nor empty.
    n_checks++;
    if ({entnum, full, empty} !== {2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_state: entnum/full/empty got %0d/%b/%b want 0/0/0", entnum, full, empty);
    end
    set_ib(0, 6'b110001, 6'b000000, 6'b000000);
    set_ib(1, 6'b110000, 6'b000000, 6'b000000);
    #1;
    n_checks++;
    if (ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL simul_pending: ready got %b want 0010", ready);
    end
    release_one(2'd3);
    n_checks++;
    if ({entnum, empty} !== {2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL release_invalid: entnum/empty got %0d/%b want 0/0", entnum, empty);
    end
    release_one(2'd1);
    release_one(2'd2);
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_drain: empty got %b want 1", empty);
    end
  endtask

  task automatic test_illegal_multi_issue();
    clear_ib();
    set_ib(0, 6'b000000, 6'b000000, 6'b100001);
    set_ib(1, 6'b000000, 6'b000000, 6'b100010);
    issue_one(4'b0011);
    n_checks++;
    if ({empty, entnum, ready} !== {1'b1, 2'd0, 4'b0011}) begin
      n_fail++;
      $display("FAIL multi_issue: empty/entnum/ready got %b/%0d/%b want 1/0/0011", empty, entnum, ready);
    end
  endtask

  task automatic test_nowrite();
    clear_ib();
    set_ib(0, 6'b000000, 6'b000000, 6'b000101);
    issue_one(4'b0001);
    n_checks++;
    if ({empty, entnum} !== {1'b0, 2'd1}) begin
      n_fail++;
      $display("FAIL nowrite_alloc: empty/entnum got %b/%0d want 0/1", empty, entnum);
    end
    set_ib(0, 6'b100101, 6'b000000, 6'b000000);
    #1;
    n_checks++;
    if (ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL nowrite_noblock: ready got %b want 0001", ready);
    end
  endtask

  task automatic test_async_reset();
    set_ib(0, 6'b000000, 6'b000000, 6'b100110);
    issue_one(4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({empty, full, entnum} !== {1'b1, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL async_reset: empty/full/entnum got %b/%b/%0d want 1/0/0", empty, full, entnum);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    fork
      begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_basic_ready();
    test_raw_inflight();
    test_ib_hazards();
    test_back_to_back_full();
    test_simultaneous();
    test_illegal_multi_issue();
    test_nowrite();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
